// File: rtl/us_distance_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// us_distance_filter : range-gated median-of-3 ultrasonic distance filter with
// stale detection. Optional output slew limit enabled by macro US_FILT_SLEW_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module us_distance_filter #(
   parameter logic [7:0]  MAX_CM       = 8'd200,
   parameter logic [23:0] STALE_CYCLES = 24'd5000000,
   parameter logic [7:0]  MAX_STEP     = 8'd4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic [7:0] RAW_DIST,
   input  logic       RAW_VALID,
   input  logic       SENSOR_IGNORE,
   output logic [7:0] DIST_OUT,
   output logic       DIST_VALID,
   output logic       DIST_STB,
   output logic       STALE,
   output logic [7:0] REJECT_CNT
);

   typedef enum logic [1:0] {
      FILL0 = 2'd0,
      FILL1 = 2'd1,
      FILL2 = 2'd2,
      RUN   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  w0_q, w0_d, w1_q, w1_d, w2_q, w2_d;
   logic [7:0]  dist_out_q, dist_out_d;
   logic        dist_valid_q, dist_valid_d;
   logic        dist_stb_q, dist_stb_d;
   logic        stale_q, stale_d;
   logic [7:0]  reject_cnt_q, reject_cnt_d;
   logic [23:0] timer_q, timer_d;

   logic       accept, reject;
   logic [7:0] median, update_val;

   function automatic logic [7:0] med3(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
      if (a >= b) begin
         if (b >= c)      med3 = b;
         else if (a >= c) med3 = c;
         else             med3 = a;
      end else begin
         if (a >= c)      med3 = a;
         else if (b >= c) med3 = c;
         else             med3 = b;
      end
   endfunction

   assign accept = RAW_VALID && !SENSOR_IGNORE && (RAW_DIST != 8'd0) && (RAW_DIST <= MAX_CM);
   assign reject = RAW_VALID && !SENSOR_IGNORE && ((RAW_DIST == 8'd0) || (RAW_DIST > MAX_CM));

   // Median of the window as it will look after the incoming sample shifts in.
   assign median = med3(RAW_DIST, w0_q, w1_q);

`ifdef US_FILT_SLEW_EN
   logic signed [8:0] diff, step;
   always_comb begin
      diff = $signed({1'b0, median}) - $signed({1'b0, dist_out_q});
      step = $signed({1'b0, MAX_STEP});
      // The first update of a fresh window loads directly, so there is no old value to slew from.
      if (state_q == FILL2)   update_val = median;
      else if (diff > step)   update_val = dist_out_q + MAX_STEP;
      else if (diff < -step)  update_val = dist_out_q - MAX_STEP;
      else                    update_val = median;
   end
`else
   logic unused_max_step;
   assign unused_max_step = ^MAX_STEP;
   assign update_val      = median;
`endif

   always_comb begin
      state_d      = state_q;
      w0_d         = w0_q;
      w1_d         = w1_q;
      w2_d         = w2_q;
      dist_out_d   = dist_out_q;
      dist_valid_d = dist_valid_q;
      dist_stb_d   = 1'b0;
      stale_d      = stale_q;
      reject_cnt_d = reject_cnt_q;
      timer_d      = timer_q;

      if (accept) begin
         timer_d = 24'd0;
         stale_d = 1'b0;
         w0_d    = RAW_DIST;
         w1_d    = w0_q;
         w2_d    = w1_q;
         case (state_q)
            FILL0:   state_d = FILL1;
            FILL1:   state_d = FILL2;
            default: begin
               state_d      = RUN;
               dist_out_d   = update_val;
               dist_valid_d = 1'b1;
               dist_stb_d   = 1'b1;
            end
         endcase
      end else if (!SENSOR_IGNORE) begin
         if (reject && (reject_cnt_q != 8'hFF))
            reject_cnt_d = reject_cnt_q + 8'd1;
         if (timer_q != STALE_CYCLES)
            timer_d = timer_q + 24'd1;
         // Stale fires on the cycle the count arrives at the limit; DIST_OUT keeps its last value.
         if ((timer_q != STALE_CYCLES) && (timer_q + 24'd1 == STALE_CYCLES)) begin
            stale_d      = 1'b1;
            dist_valid_d = 1'b0;
            state_d      = FILL0;
            w0_d         = 8'd0;
            w1_d         = 8'd0;
            w2_d         = 8'd0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= FILL0;
         w0_q         <= 8'd0;
         w1_q         <= 8'd0;
         w2_q         <= 8'd0;
         dist_out_q   <= 8'd0;
         dist_valid_q <= 1'b0;
         dist_stb_q   <= 1'b0;
         stale_q      <= 1'b0;
         reject_cnt_q <= 8'd0;
         timer_q      <= 24'd0;
      end else begin
         state_q      <= state_d;
         w0_q         <= w0_d;
         w1_q         <= w1_d;
         w2_q         <= w2_d;
         dist_out_q   <= dist_out_d;
         dist_valid_q <= dist_valid_d;
         dist_stb_q   <= dist_stb_d;
         stale_q      <= stale_d;
         reject_cnt_q <= reject_cnt_d;
         timer_q      <= timer_d;
      end
   end

   // w2 is the oldest entry; it ages out of the window and feeds nothing else.
   logic unused_w2;
   assign unused_w2 = ^w2_q;

   assign DIST_OUT   = dist_out_q;
   assign DIST_VALID = dist_valid_q;
   assign DIST_STB   = dist_stb_q;
   assign STALE      = stale_q;
   assign REJECT_CNT = reject_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_us_distance_filter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_us_distance_filter : directed vector table plus multi-cycle sequences.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_us_distance_filter;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic [7:0] RAW_DIST = 8'd0;
   logic       RAW_VALID = 1'b0;
   logic       SENSOR_IGNORE = 1'b0;
   logic [7:0] DIST_OUT;
   logic       DIST_VALID;
   logic       DIST_STB;
   logic       STALE;
   logic [7:0] REJECT_CNT;

   int checks = 0;
   int failures = 0;

   us_distance_filter #(
      .MAX_CM      (8'd200),
      .STALE_CYCLES(24'd100),
      .MAX_STEP    (8'd4)
   ) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .RAW_DIST     (RAW_DIST),
      .RAW_VALID    (RAW_VALID),
      .SENSOR_IGNORE(SENSOR_IGNORE),
      .DIST_OUT     (DIST_OUT),
      .DIST_VALID   (DIST_VALID),
      .DIST_STB     (DIST_STB),
      .STALE        (STALE),
      .REJECT_CNT   (REJECT_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ign;
      logic [7:0] e_out;
      logic       e_valid;
      logic       e_stb;
      logic       e_stale;
      logic [7:0] e_rej;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the edge that captured them.
   task automatic cyc(input logic v, input logic [7:0] d, input logic ign);
      RAW_VALID     = v;
      RAW_DIST      = d;
      SENSOR_IGNORE = ign;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_all(input string tag, input int o, input int va, input int s,
                          input int st, input int r);
      chk({tag, "_out"},   int'(DIST_OUT),   o);
      chk({tag, "_valid"}, int'(DIST_VALID), va);
      chk({tag, "_stb"},   int'(DIST_STB),   s);
      chk({tag, "_stale"}, int'(STALE),      st);
      chk({tag, "_rej"},   int'(REJECT_CNT), r);
   endtask

   int stb_seen;

   initial begin
      //           v     d       ign   out     val   stb   stale rej
      vecs[0]  = '{1'b1, 8'd30,  1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 8'd90,  1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 8'd32,  1'b0, 8'd32,  1'b1, 1'b1, 1'b0, 8'd0};
      vecs[3]  = '{1'b0, 8'd0,   1'b0, 8'd32,  1'b1, 1'b0, 1'b0, 8'd0};
      vecs[4]  = '{1'b1, 8'd31,  1'b0, 8'd32,  1'b1, 1'b1, 1'b0, 8'd0};  // {31,32,90}
      vecs[5]  = '{1'b1, 8'd31,  1'b0, 8'd31,  1'b1, 1'b1, 1'b0, 8'd0};  // {31,31,32}
      vecs[6]  = '{1'b1, 8'd0,   1'b0, 8'd31,  1'b1, 1'b0, 1'b0, 8'd1};
      vecs[7]  = '{1'b1, 8'd201, 1'b0, 8'd31,  1'b1, 1'b0, 1'b0, 8'd2};
      vecs[8]  = '{1'b1, 8'd255, 1'b0, 8'd31,  1'b1, 1'b0, 1'b0, 8'd3};
      vecs[9]  = '{1'b1, 8'd40,  1'b0, 8'd31,  1'b1, 1'b1, 1'b0, 8'd3};  // {40,31,31}
      vecs[10] = '{1'b1, 8'd40,  1'b0, 8'd40,  1'b1, 1'b1, 1'b0, 8'd3};  // {40,40,31}
      vecs[11] = '{1'b1, 8'd200, 1'b0, 8'd40,  1'b1, 1'b1, 1'b0, 8'd3};  // {200,40,40}
      vecs[12] = '{1'b1, 8'd200, 1'b0, 8'd200, 1'b1, 1'b1, 1'b0, 8'd3};  // {200,200,40}
      vecs[13] = '{1'b1, 8'd0,   1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[14] = '{1'b1, 8'd40,  1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 8'd3};
      vecs[15] = '{1'b0, 8'd0,   1'b0, 8'd200, 1'b1, 1'b0, 1'b0, 8'd3};

      RESET = 1'b1;
      cyc(1'b0, 8'd0, 1'b0);
      cyc(1'b0, 8'd0, 1'b0);
      RESET = 1'b0;
      chk_all("reset", 0, 0, 0, 0, 0);

      for (int i = 0; i < NV; i++) begin
         cyc(vecs[i].v, vecs[i].d, vecs[i].ign);
         chk_all($sformatf("vec%0d", i), int'(vecs[i].e_out), int'(vecs[i].e_valid),
                 int'(vecs[i].e_stb), int'(vecs[i].e_stale), int'(vecs[i].e_rej));
      end

      // Stale: restart timer with an accept, then go quiet for exactly STALE_CYCLES.
      cyc(1'b1, 8'd200, 1'b0);
      chk_all("stale_pre", 200, 1, 1, 0, 3);
      for (int i = 0; i < 99; i++) cyc(1'b0, 8'd0, 1'b0);
      chk_all("stale_99", 200, 1, 0, 0, 3);
      cyc(1'b0, 8'd0, 1'b0);
      chk_all("stale_100", 200, 0, 0, 1, 3);
      cyc(1'b1, 8'd10, 1'b0);
      chk_all("refill1", 200, 0, 0, 0, 3);
      cyc(1'b1, 8'd20, 1'b0);
      chk_all("refill2", 200, 0, 0, 0, 3);
      cyc(1'b1, 8'd30, 1'b0);
      chk_all("refill3", 20, 1, 1, 0, 3);

      // Accept lands on the same cycle the timer would reach the limit.
      for (int i = 0; i < 99; i++) cyc(1'b0, 8'd0, 1'b0);
      cyc(1'b1, 8'd25, 1'b0);
      chk_all("race", 25, 1, 1, 0, 3);

      // Ignore window: no counting, no updates, timer frozen.
      stb_seen = 0;
      for (int i = 0; i < 500; i++) begin
         cyc(1'b1, (i % 2 == 0) ? 8'd0 : 8'd40, 1'b1);
         if (DIST_STB) stb_seen++;
      end
      chk("ign_stb_count", stb_seen, 0);
      chk_all("ign_end", 25, 1, 0, 0, 3);
      for (int i = 0; i < 99; i++) cyc(1'b0, 8'd0, 1'b0);
      chk("ign_frozen_stale", int'(STALE), 0);
      cyc(1'b0, 8'd0, 1'b0);
      chk("ign_then_stale", int'(STALE), 1);

      // Reset mid-RUN with a valid sample present.
      cyc(1'b1, 8'd50, 1'b0);
      cyc(1'b1, 8'd50, 1'b0);
      cyc(1'b1, 8'd50, 1'b0);
      chk_all("run50", 50, 1, 1, 0, 3);
      RESET = 1'b1;
      cyc(1'b1, 8'd50, 1'b0);
      RESET = 1'b0;
      chk_all("mid_reset", 0, 0, 0, 0, 0);
      cyc(1'b1, 8'd50, 1'b0);
      chk_all("post_rst1", 0, 0, 0, 0, 0);
      cyc(1'b1, 8'd50, 1'b0);
      chk_all("post_rst2", 0, 0, 0, 0, 0);
      cyc(1'b1, 8'd50, 1'b0);
      chk_all("post_rst3", 50, 1, 1, 0, 0);

      // Reject counter saturation; the quiet period also trips stale.
      for (int i = 0; i < 300; i++) cyc(1'b1, (i % 2 == 0) ? 8'd0 : 8'd250, 1'b0);
      chk("rej_sat", int'(REJECT_CNT), 255);
      chk("rej_sat_stale", int'(STALE), 1);
      chk("rej_sat_out", int'(DIST_OUT), 50);
      cyc(1'b0, 8'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
